// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, branch, fetch-wait, data-memory-wait
// and multi-cycle mul/div conditions into stall/bubble enable-clear pairs.
module pipeline_hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter int unsigned DMEM_TIMEOUT  = 255,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_use_rs1,
    input  logic       i_id_use_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_is_load,
    input  logic       i_ex_branch_taken,
    input  logic       i_ex_muldiv_start,
    input  logic       i_imem_ready,
    input  logic       i_mem_req,
    input  logic       i_dmem_ready,
    output logic       o_pc_enable,
    output logic       o_ifid_enable,
    output logic       o_ifid_clear,
    output logic       o_idex_enable,
    output logic       o_idex_clear,
    output logic       o_exmem_enable,
    output logic       o_exmem_clear,
    output logic       o_memwb_enable,
    output logic       o_memwb_clear,
    output logic       o_muldiv_busy,
    output logic       o_bus_error
);

    typedef enum logic {StIdle, StWait} dmem_state_e;

    // The start cycle is itself a stall cycle, so the countdown covers the remaining
    // MULDIV_CYCLES-1 cycles to give exactly MULDIV_CYCLES stalled cycles in total.
    localparam logic [CNT_W-1:0] MdLoad  = CNT_W'(MULDIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] DmLimit = CNT_W'(DMEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             bus_error_q;

    logic timeout_hit, dstall, mstall, lu, br, fstall;

    assign timeout_hit = (state_q == StWait) && (wcnt_q == DmLimit);
    assign dstall      = i_mem_req & ~i_dmem_ready & ~timeout_hit;
    assign mstall      = i_ex_muldiv_start & ~(busy_q & (cnt_q == '0));
    assign lu          = i_ex_is_load & (i_ex_rd != 5'd0) &
                         ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                          (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
    assign br          = i_ex_branch_taken;
    assign fstall      = ~i_imem_ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            StIdle: begin
                wcnt_d = '0;
                if (i_mem_req & ~i_dmem_ready) begin
                    state_d = StWait;
                    wcnt_d  = CntOne;
                end
            end
            StWait: begin
                wcnt_d = wcnt_q + CntOne;
                if (i_dmem_ready | ~i_mem_req | timeout_hit) begin
                    state_d = StIdle;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                wcnt_d  = '0;
            end
        endcase
    end

    // The countdown freezes while MEM stalls, since EX cannot retire then either.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (!busy_q) begin
            if (i_ex_muldiv_start) begin
                busy_d = 1'b1;
                cnt_d  = MdLoad;
            end
        end else if (!dstall) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            wcnt_q      <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            bus_error_q <= timeout_hit;
        end
    end

    always_comb begin
        o_pc_enable    = 1'b1;
        o_ifid_enable  = 1'b1;
        o_ifid_clear   = 1'b0;
        o_idex_enable  = 1'b1;
        o_idex_clear   = 1'b0;
        o_exmem_enable = 1'b1;
        o_exmem_clear  = 1'b0;
        o_memwb_enable = 1'b1;
        o_memwb_clear  = 1'b0;
        if (dstall) begin
            o_pc_enable    = 1'b0;
            o_ifid_enable  = 1'b0;
            o_idex_enable  = 1'b0;
            o_exmem_enable = 1'b0;
            o_memwb_clear  = 1'b1;
        end else if (mstall) begin
            o_pc_enable   = 1'b0;
            o_ifid_enable = 1'b0;
            o_idex_enable = 1'b0;
            o_exmem_clear = 1'b1;
        end else if (br) begin
            o_ifid_clear = 1'b1;
            o_idex_clear = 1'b1;
        end else if (lu) begin
            o_pc_enable   = 1'b0;
            o_ifid_enable = 1'b0;
            o_idex_clear  = 1'b1;
        end else if (fstall) begin
            o_pc_enable  = 1'b0;
            o_ifid_clear = 1'b1;
        end
    end

    assign o_muldiv_busy = busy_q;
    assign o_bus_error   = bus_error_q;

endmodule
